// File: rtl/mem_request_arbiter.sv
// N-channel memory request arbiter onto a single RAM port.
// Fixed-priority or round-robin grant, busy handshake, access timeout.
module mem_request_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_wen,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [NUM_CH-1:0]          req_err,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [$clog2(NUM_CH)-1:0]  grant_id,
    output logic                       ram_ren,
    output logic                       ram_wen,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wdata,
    input  logic [DATA_W-1:0]          ram_rdata,
    input  logic                       ram_busy
);

    localparam int GW = $clog2(NUM_CH);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [NUM_CH-1:0] err_q, err_d;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign ch_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] v);
        return (v == GW'(NUM_CH-1)) ? '0 : v + GW'(1);
    endfunction

    // Round-robin starts one past the last grant; fixed priority starts at 0.
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = (RR_EN != 0) ? nxt(last_q) : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = nxt(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        rdata_d = '0;
        ready_d = '0;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = win;
                    addr_d  = ch_addr[win];
                    wdata_d = ch_wdata[win];
                    wen_d   = req_wen[win];
                    ren_d   = !req_wen[win];
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ren_d = ren_q;
                wen_d = wen_q;
                if (!ram_busy) begin
                    rdata_d          = wen_q ? '0 : ram_rdata;
                    ready_d[grant_q] = 1'b1;
                    ren_d            = 1'b0;
                    wen_d            = 1'b0;
                    state_d          = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    ready_d[grant_q] = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    ren_d            = 1'b0;
                    wen_d            = 1'b0;
                    state_d          = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH-1);
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign req_err   = err_q;
    assign req_rdata = rdata_q;
    assign grant_id  = grant_q;
    assign ram_ren   = ren_q;
    assign ram_wen   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter with a response scoreboard.
// dut0: 2 channels, fixed priority, TIMEOUT=4; dut1: 4 channels, round-robin.
module tb_mem_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    logic        rst0;
    logic [1:0]  v0, w0, rdy0, er0;
    logic [63:0] a0, d0;
    logic [31:0] rd0, ao0, wdo0, rrd0;
    logic [0:0]  g0;
    logic        ren0, wen0, busy0;

    logic         rst1;
    logic [3:0]   v1, w1, rdy1, er1;
    logic [127:0] a1, d1;
    logic [31:0]  rd1, ao1, wdo1, rrd1;
    logic [1:0]   g1;
    logic         ren1, wen1, busy1;

    mem_request_arbiter #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(4)
    ) dut0 (
        .clk(clk), .reset(rst0),
        .req_valid(v0), .req_wen(w0), .req_addr(a0), .req_wdata(d0),
        .req_ready(rdy0), .req_err(er0), .req_rdata(rd0), .grant_id(g0),
        .ram_ren(ren0), .ram_wen(wen0), .ram_addr(ao0), .ram_wdata(wdo0),
        .ram_rdata(rrd0), .ram_busy(busy0)
    );

    mem_request_arbiter #(
        .NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(16)
    ) dut1 (
        .clk(clk), .reset(rst1),
        .req_valid(v1), .req_wen(w1), .req_addr(a1), .req_wdata(d1),
        .req_ready(rdy1), .req_err(er1), .req_rdata(rd1), .grant_id(g1),
        .ram_ren(ren1), .ram_wen(wen1), .ram_addr(ao1), .ram_wdata(wdo1),
        .ram_rdata(rrd1), .ram_busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] rd, input logic err);
        exp_t e;
        e.ch    = ch;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic check_resp(input int which, input string tag);
        exp_t        e;
        logic [3:0]  rdy, er, ev;
        logic [31:0] rd;
        if (which == 0) begin
            rdy = {2'b00, rdy0};
            er  = {2'b00, er0};
            rd  = rd0;
        end else begin
            rdy = rdy1;
            er  = er1;
            rd  = rd1;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
            return;
        end
        e  = sb.pop_front();
        ev = 4'(1) << e.ch;
        chk({tag, ".ready"}, 32'(rdy), 32'(ev));
        chk({tag, ".rdata"}, rd, e.rdata);
        chk({tag, ".err"}, 32'(er), e.err ? 32'(ev) : 32'd0);
    endtask

    initial begin
        rst0 = 1'b1; v0 = '0; w0 = '0; a0 = '0; d0 = '0;
        rrd0 = '0; busy0 = 1'b0;
        rst1 = 1'b1; v1 = '0; w1 = '0; a1 = '0; d1 = '0;
        rrd1 = '0; busy1 = 1'b0;
        step();
        step();

        // reset state
        chk("rst0.ready", 32'(rdy0), 0);
        chk("rst0.err", 32'(er0), 0);
        chk("rst0.rdata", rd0, 0);
        chk("rst0.grant", 32'(g0), 0);
        chk("rst0.ren", 32'(ren0), 0);
        chk("rst0.wen", 32'(wen0), 0);
        chk("rst0.addr", ao0, 0);
        chk("rst0.wdata", wdo0, 0);
        chk("rst1.ready", 32'(rdy1), 0);
        chk("rst1.grant", 32'(g1), 0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // single read on ch1
        v0 = 2'b10; w0 = 2'b00; a0[63:32] = 32'h100;
        rrd0 = 32'hDEADBEEF; busy0 = 1'b0;
        push(1, 32'hDEADBEEF, 1'b0);
        step();
        chk("rd.ren", 32'(ren0), 1);
        chk("rd.wen", 32'(wen0), 0);
        chk("rd.addr", ao0, 32'h100);
        chk("rd.grant", 32'(g0), 1);
        chk("rd.c1ready", 32'(rdy0), 0);
        step();
        check_resp(0, "rd");
        v0 = 2'b00;
        step();
        chk("rd.c3ready", 32'(rdy0), 0);
        chk("rd.c3rdata", rd0, 0);
        chk("rd.c3ren", 32'(ren0), 0);
        chk("rd.c3addr", ao0, 32'h100);

        // fixed-priority collision: ch0 write vs ch1 read
        v0 = 2'b11; w0 = 2'b01;
        a0 = {32'h8, 32'h4}; d0 = {32'h0, 32'h55};
        rrd0 = 32'h12345678;
        push(0, 32'h0, 1'b0);
        push(1, 32'h12345678, 1'b0);
        step();
        chk("col.wen", 32'(wen0), 1);
        chk("col.ren", 32'(ren0), 0);
        chk("col.wdata", wdo0, 32'h55);
        chk("col.addr", ao0, 32'h4);
        chk("col.grant0", 32'(g0), 0);
        step();
        check_resp(0, "col0");
        v0 = 2'b10; w0 = 2'b00;
        step();
        chk("col.idle", 32'(rdy0), 0);
        step();
        chk("col.ren1", 32'(ren0), 1);
        chk("col.addr1", ao0, 32'h8);
        chk("col.grant1", 32'(g0), 1);
        step();
        check_resp(0, "col1");
        v0 = 2'b00;
        step();

        // ch0 held valid starves ch1
        v0 = 2'b11; w0 = 2'b00; a0 = {32'h8, 32'h20};
        rrd0 = 32'h77;
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h77, 1'b0);
            step();
            chk("starve.grant", 32'(g0), 0);
            chk("starve.addr", ao0, 32'h20);
            step();
            check_resp(0, "starve");
            if (i == 3) v0 = 2'b00;
            step();
        end

        // timeout with busy stuck high
        v0 = 2'b10; w0 = 2'b00; a0[63:32] = 32'h40;
        busy0 = 1'b1; rrd0 = 32'hFFFFFFFF;
        push(1, 32'h0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("tmo.ren", 32'(ren0), 1);
            chk("tmo.noready", 32'(rdy0), 0);
        end
        step();
        check_resp(0, "tmo");
        chk("tmo.ren_low", 32'(ren0), 0);
        chk("tmo.wen_low", 32'(wen0), 0);
        v0 = 2'b00; busy0 = 1'b0;
        step();
        v0 = 2'b01; a0[31:0] = 32'h50; rrd0 = 32'hA5A5A5A5;
        push(0, 32'hA5A5A5A5, 1'b0);
        step();
        chk("tmo.next_ren", 32'(ren0), 1);
        chk("tmo.next_grant", 32'(g0), 0);
        chk("tmo.next_addr", ao0, 32'h50);
        step();
        check_resp(0, "tmo.next");
        v0 = 2'b00;
        step();

        // round-robin, all four channels valid
        v1 = 4'hF; w1 = 4'h0; busy1 = 1'b0; rrd1 = 32'hC0DE0000;
        for (int c = 0; c < 4; c++) a1[c*32 +: 32] = 32'h1000 + 32'(4*c);
        for (int i = 0; i < 5; i++) begin
            push(i % 4, 32'hC0DE0000, 1'b0);
            step();
            chk("rr.grant", 32'(g1), 32'(i % 4));
            chk("rr.addr", ao1, 32'h1000 + 32'(4*(i % 4)));
            step();
            check_resp(1, "rr");
            if (i == 4) v1 = 4'h0;
            step();
        end

        // busy stretch of three cycles on ch2
        v1 = 4'b0100; a1[64 +: 32] = 32'h2000;
        busy1 = 1'b1; rrd1 = 32'hFFFFFFFF;
        push(2, 32'h0BADF00D, 1'b0);
        step();
        chk("bsy.ren", 32'(ren1), 1);
        chk("bsy.grant", 32'(g1), 2);
        step();
        chk("bsy.c2ready", 32'(rdy1), 0);
        step();
        chk("bsy.c3ready", 32'(rdy1), 0);
        step();
        busy1 = 1'b0; rrd1 = 32'h0BADF00D;
        chk("bsy.c4ready", 32'(rdy1), 0);
        chk("bsy.c4ren", 32'(ren1), 1);
        step();
        check_resp(1, "bsy");
        rrd1 = 32'hFFFFFFFF; v1 = 4'h0;
        step();

        // reset in the middle of a busy read on ch3
        v1 = 4'b1000; a1[96 +: 32] = 32'h3000; busy1 = 1'b1;
        step();
        chk("mrst.grant", 32'(g1), 3);
        chk("mrst.ren", 32'(ren1), 1);
        step();
        rst1 = 1'b1;
        step();
        chk("mrst.ready", 32'(rdy1), 0);
        chk("mrst.err", 32'(er1), 0);
        chk("mrst.rdata", rd1, 0);
        chk("mrst.grant0", 32'(g1), 0);
        chk("mrst.ren0", 32'(ren1), 0);
        chk("mrst.wen0", 32'(wen1), 0);
        chk("mrst.addr0", ao1, 0);
        chk("mrst.wdata0", wdo1, 0);
        rst1 = 1'b0; v1 = 4'hF; busy1 = 1'b0; rrd1 = 32'h11112222;
        push(0, 32'h11112222, 1'b0);
        step();
        chk("mrst.first_grant", 32'(g1), 0);
        chk("mrst.first_addr", ao1, 32'h1000);
        step();
        check_resp(1, "mrst.first");
        v1 = 4'h0;
        step();

        chk("sb.empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Parametrised memory request unit that arbitrates NUM_CH requesters (instruction fetch, data load/store, debug, …) onto one shared RAM port. It sits between the CPU datapath and RAM and generalises the two-port fetch/data request unit to N channels. It offers fixed-priority or round-robin arbitration, a RAM busy handshake, and a per-access timeout that reports an error instead of hanging the core.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels (≥2)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- RR_EN, 0: 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 16: max ACCESS cycles with ram_busy high before abort (≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request
- req_wen  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  flattened; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  flattened write data
- req_ready  out  NUM_CH  one-cycle completion pulse to the granted channel
- req_err  out  NUM_CH  one-cycle timeout pulse, coincident with req_ready
- req_rdata  out  DATA_W  read data, valid while req_ready is high
- grant_id  out  $clog2(NUM_CH)  channel being serviced
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- ram_busy  in  1  RAM not finished this cycle

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - If any req_valid bit is set, pick a winner g.
  - Latch grant_id=g, plus addr, wdata and wen of channel g.
  - Clear the timeout counter and go to ACCESS.
- **ACCESS**
  - Drive ram_wen = latched wen and ram_ren = !latched wen. The two strobes are never high together.
  - If ram_busy=0: capture ram_rdata (or 0 for a write) and go to RESP.
  - If ram_busy=1: increment the counter. When the counter reaches TIMEOUT-1 with busy still high, set the error flag, force rdata to 0 and go to RESP.
- **RESP**
  - Pulse req_ready[g] (and req_err[g] if the error flag is set) and drive req_rdata.
  - Strobes are low. Update last_grant=g, then return to IDLE.
- **Arbitration**
  - RR_EN=0: the lowest set index wins, so a continuously asserted low channel can starve higher ones (intended for data-over-fetch).
  - RR_EN=1: search upward from (last_grant+1) mod NUM_CH, wrapping at NUM_CH-1 back to 0.
- **Requester rules**
  - A requester holds valid, wen, addr and wdata stable until its req_ready.
  - Inputs are sampled only in IDLE. Dropping valid mid-access does not cancel the access; the ready pulse still occurs.
- **Outputs outside their states**
  - req_ready, req_err, req_rdata are 0 outside RESP.
  - ram_addr and ram_wdata hold their latched values in IDLE and RESP.

## Timing
- **Reset** (sync, active-high) forces, at the next edge:
  - state=IDLE
  - ram_ren=ram_wen=0, ram_addr=0, ram_wdata=0
  - req_ready=0, req_err=0, req_rdata=0, grant_id=0
  - counter=0, last_grant=NUM_CH-1, so ch0 is first under round-robin
- Reset during ACCESS or RESP aborts with no ready pulse. The in-flight RAM write may or may not have taken effect.
- **Latency**
  - Valid sampled in IDLE at cycle 0; strobe high from cycle 1.
  - With ram_busy low at cycle 1, req_ready is high in cycle 2 and the FSM is back in IDLE in cycle 3.
  - Each extra busy cycle adds one cycle, so ready arrives at cycle 2+B for B busy cycles, where B < TIMEOUT-1.
- **Timeout:** with busy stuck high, RESP (error) occurs at cycle 1+TIMEOUT.
- **Throughput:** at most one access per 3 cycles.
- **Simultaneous requests:** requests arriving while not in IDLE wait. Requests arriving in the same IDLE cycle are resolved by the arbitration rule.

## Test plan
- **Single read:** NUM_CH=2; ch1 reads 0x100; RAM returns 0xDEADBEEF with busy=0. Required: ram_ren and ram_addr=0x100 in cycle 1; req_ready=2'b10 and req_rdata=0xDEADBEEF in cycle 2; req_err=0.
- **Fixed-priority collision:** RR_EN=0; ch0 writes 0x55 to 0x4 while ch1 reads 0x8, both in the same cycle. Required: ch0 served first (ram_wen, ram_wdata=0x55), then ch1 ready 3 cycles later. With ch0 held valid continuously, ch1 is never granted.
- **Round-robin:** RR_EN=1, NUM_CH=4, all valid continuously. Required: grant_id sequence 0,1,2,3,0 across successive accesses.
- **Busy stretch:** ram_busy high for 3 ACCESS cycles, then low. Required: req_ready in cycle 5, with correct rdata latched when busy=0.
- **Timeout:** TIMEOUT=4, ram_busy stuck high. Required: req_ready and req_err pulse together in cycle 5, req_rdata=0, strobes drop, FSM accepts a new request in cycle 6.
- **Reset mid-access:** reset asserted in cycle 2 of a busy read. Required: next edge gives all outputs 0 and state IDLE, with no req_ready pulse; after reset release under RR_EN=1, ch0 is granted first.
